// File: rtl/barrel_pkg.sv
// Shared types and constants for the four-thread barrel scheduler.
package barrel_pkg;

    localparam int NTHREADS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FAULT = 2'b10
    } thread_state_e;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_START = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    localparam logic [1:0] D_PUSH = 2'b01;
    localparam logic [1:0] D_POP  = 2'b11;

    function automatic logic is_push(input logic [1:0] delta);
        return (delta == D_PUSH);
    endfunction

    function automatic logic is_pop(input logic [1:0] delta);
        return (delta == D_POP);
    endfunction

endpackage

// File: rtl/barrel_sched_if.sv
// Core stack-op and host command signals of the barrel scheduler.
interface barrel_sched_if;
    import barrel_pkg::*;

    logic [1:0]          slot;
    logic                issue;
    logic                core_we;
    logic [1:0]          core_delta;
    logic                stk_we;
    logic [1:0]          stk_delta;
    logic                ctl_valid;
    logic                ctl_ready;
    logic [1:0]          ctl_thread;
    logic [1:0]          ctl_cmd;
    logic [NTHREADS-1:0] run_mask;
    logic [NTHREADS-1:0] fault_mask;

    modport slave (
        input  core_we, core_delta, ctl_valid, ctl_thread, ctl_cmd,
        output slot, issue, stk_we, stk_delta, ctl_ready, run_mask, fault_mask
    );

    modport master (
        output core_we, core_delta, ctl_valid, ctl_thread, ctl_cmd,
        input  slot, issue, stk_we, stk_delta, ctl_ready, run_mask, fault_mask
    );

endinterface

// File: rtl/barrel_thread_ctx.sv
// Per-thread run state and, with STACK_CHECK_EN defined, stack depth tracking
// with overflow/underflow fault entry.
module barrel_thread_ctx
    import barrel_pkg::*;
#(
    parameter int DEPTH = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel,
    input  logic [1:0]    core_delta,
    input  logic          cmd_stb,
    input  cmd_e          cmd,
    output thread_state_e state,
    output logic          would_fault
);

    thread_state_e state_q, state_d;

`ifdef STACK_CHECK_EN
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0] ONE       = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] depth_q, depth_d;
`else
    logic unused_delta;
    assign unused_delta = ^core_delta;
`endif

    assign state = state_q;

    // Next state/depth: a fault in this slot wins over any command that cycle.
    always_comb begin
        state_d = state_q;
`ifdef STACK_CHECK_EN
        depth_d     = depth_q;
        would_fault = (state_q == RUN) &&
                      (((depth_q == DEPTH_MAX) && is_push(core_delta)) ||
                       ((depth_q == {DW{1'b0}}) && is_pop(core_delta)));
`else
        would_fault = 1'b0;
`endif
        if (sel && would_fault) begin
            state_d = FAULT;
        end else if (sel) begin
`ifdef STACK_CHECK_EN
            if (state_q == RUN && is_push(core_delta)) begin
                depth_d = depth_q + ONE;
            end else if (state_q == RUN && is_pop(core_delta)) begin
                depth_d = depth_q - ONE;
            end else begin
                depth_d = depth_q;
            end
`endif
            if (cmd_stb) begin
                case (cmd)
                    CMD_START: begin
                        if (state_q == IDLE) begin
                            state_d = RUN;
`ifdef STACK_CHECK_EN
                            depth_d = {DW{1'b0}};
`endif
                        end else begin
                            state_d = state_q;
                        end
                    end
                    CMD_STOP: begin
                        if (state_q == RUN) begin
                            state_d = IDLE;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    CMD_CLEAR: begin
                        if (state_q == FAULT) begin
                            state_d = IDLE;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Thread state (and depth) registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
`ifdef STACK_CHECK_EN
            depth_q <= {DW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
`ifdef STACK_CHECK_EN
            depth_q <= depth_d;
`endif
        end
    end

endmodule

// File: rtl/barrel_sched.sv
// Four-thread barrel scheduler: free-running slot counter, host command
// handshake and per-slot gating of stack ops. Optional feature: STACK_CHECK_EN.
module barrel_sched
    import barrel_pkg::*;
#(
    parameter int DEPTH = 18
) (
    input  logic           clk,
    input  logic           reset,
    barrel_sched_if.slave  bus
);

    logic [1:0]          slot_q, slot_d;
    thread_state_e       th_state [NTHREADS];
    logic [NTHREADS-1:0] th_wf;
    logic                ctl_accept_s;
    logic                issue_s;
    cmd_e                cmd_s;

    assign cmd_s        = cmd_e'(bus.ctl_cmd);
    assign ctl_accept_s = bus.ctl_valid & (bus.ctl_thread == slot_q) & ~reset;
    assign bus.slot     = slot_q;

    for (genvar t = 0; t < NTHREADS; t++) begin : g_thread
        barrel_thread_ctx #(.DEPTH(DEPTH)) u_ctx (
            .clk         (clk),
            .reset       (reset),
            .sel         (slot_q == 2'(t)),
            .core_delta  (bus.core_delta),
            .cmd_stb     (ctl_accept_s & (slot_q == 2'(t))),
            .cmd         (cmd_s),
            .state       (th_state[t]),
            .would_fault (th_wf[t])
        );
    end

    // Slot-head gating is evaluated against the pre-update thread state.
    always_comb begin
        slot_d        = slot_q + 2'd1;
        issue_s       = ~reset & (th_state[slot_q] == RUN) & ~th_wf[slot_q];
        bus.issue     = issue_s;
        bus.ctl_ready = ctl_accept_s;
        bus.stk_we    = bus.core_we & issue_s;
        if (issue_s) begin
            bus.stk_delta = bus.core_delta;
        end else begin
            bus.stk_delta = 2'b00;
        end
        for (int t = 0; t < NTHREADS; t++) begin
            bus.run_mask[t] = (th_state[t] == RUN);
`ifdef STACK_CHECK_EN
            bus.fault_mask[t] = (th_state[t] == FAULT);
`else
            bus.fault_mask[t] = 1'b0;
`endif
        end
    end

    // Slot counter never stalls; the stack rotator advances every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= 2'd0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: tb/tb_barrel_sched.sv
// Randomized self-checking bench for barrel_sched against a thread-level model.
module tb_barrel_sched;

`ifdef STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DEPTH = 18;
    localparam int S_IDLE = 0, S_RUN = 1, S_FAULT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    barrel_sched_if bus ();

    barrel_sched #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad = 0;

    int m_slot = 0, n_slot = 0;
    int m_st [4] = '{S_IDLE, S_IDLE, S_IDLE, S_IDLE};
    int n_st [4] = '{S_IDLE, S_IDLE, S_IDLE, S_IDLE};
    int m_d  [4] = '{0, 0, 0, 0};
    int n_d  [4] = '{0, 0, 0, 0};

    logic [14:0] exp_v;
    logic        exp_ready;
    logic [14:0] obs_v;
    assign obs_v = {bus.slot, bus.issue, bus.stk_we, bus.stk_delta, bus.ctl_ready,
                    bus.run_mask, bus.fault_mask};

    // One cycle: drive inputs, predict outputs, and compute next model state.
    task automatic drive(input logic r, input logic we, input logic [1:0] dl,
                         input logic v, input logic [1:0] th, input logic [1:0] cm);
        int s;
        bit wf, iss, rdy;
        logic [3:0] rm, fm;
        @(negedge clk);
        m_slot = n_slot; m_st = n_st; m_d = n_d;
        reset = r;
        bus.core_we = we; bus.core_delta = dl;
        bus.ctl_valid = v; bus.ctl_thread = th; bus.ctl_cmd = cm;
        #1;
        s   = m_slot;
        wf  = CHK && (m_st[s] == S_RUN) &&
              ((m_d[s] == DEPTH && dl == 2'b01) || (m_d[s] == 0 && dl == 2'b11));
        iss = !r && (m_st[s] == S_RUN) && !wf;
        rdy = v && (int'(th) == s) && !r;
        for (int i = 0; i < 4; i++) begin
            rm[i] = (m_st[i] == S_RUN);
            fm[i] = (m_st[i] == S_FAULT);
        end
        exp_v = {2'(s), iss, we & iss, iss ? dl : 2'b00, rdy, rm, fm};
        exp_ready = rdy;
        n_slot = m_slot; n_st = m_st; n_d = m_d;
        if (r) begin
            n_slot = 0;
            for (int i = 0; i < 4; i++) begin n_st[i] = S_IDLE; n_d[i] = 0; end
        end else begin
            n_slot = (s + 1) % 4;
            if (wf) begin
                n_st[s] = S_FAULT;
            end else begin
                if (iss && dl == 2'b01) n_d[s] = m_d[s] + 1;
                if (iss && dl == 2'b11) n_d[s] = m_d[s] - 1;
                if (rdy) begin
                    if (cm == 2'b01 && m_st[s] == S_IDLE) begin n_st[s] = S_RUN; n_d[s] = 0; end
                    if (cm == 2'b10 && m_st[s] == S_RUN)   n_st[s] = S_IDLE;
                    if (cm == 2'b11 && m_st[s] == S_FAULT) n_st[s] = S_IDLE;
                end
            end
        end
    endtask

    task automatic idle_to(input int target);
        for (int i = 0; i < 4 && n_slot != target; i++)
            drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    endtask

    // Holds a command until the model says it is accepted; k = wait cycles.
    task automatic host_cmd(input logic [1:0] th, input logic [1:0] cm, output int k);
        k = -1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'b00, 1'b1, th, cm);
            total++;
            if (obs_v !== exp_v) begin
                bad++; $display("FAIL host_cmd t%0d c%0d got=%h want=%h", th, cm, obs_v, exp_v);
            end
            if (exp_ready) begin k = i; break; end
        end
        if (k < 0) begin
            bad++; $display("FAIL host_cmd_timeout t%0d got=no_ready want=ready", th);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        drive(1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01);
        total++;
        if (obs_v !== exp_v || bus.slot !== 2'd0 || bus.ctl_ready !== 1'b0 ||
            bus.run_mask !== 4'b0000 || bus.stk_we !== 1'b0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'($urandom), 2'($urandom), 1'b0, 2'b00, 2'b00);
            total++;
            if (obs_v !== exp_v || bus.slot !== 2'(i % 4) || bus.stk_we !== 1'b0 ||
                bus.stk_delta !== 2'b00 || bus.run_mask !== 4'b0000) begin
                bad++; $display("FAIL idle cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_start_latency();
        int k, first;
        idle_to(3);
        host_cmd(2'd2, 2'b01, k);
        total++;
        if (k !== 3) begin bad++; $display("FAIL start_ready_wait got=%0d want=3", k); end
        first = -1;
        for (int j = 1; j <= 8; j++) begin
            drive(1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
            total++;
            if (obs_v !== exp_v) begin
                bad++; $display("FAIL start_cycle j%0d got=%h want=%h", j, obs_v, exp_v);
            end
            if (j == 1) begin
                total++;
                if (bus.run_mask !== 4'b0100) begin
                    bad++; $display("FAIL start_run_mask got=%b want=0100", bus.run_mask);
                end
            end
            if (first < 0 && bus.issue === 1'b1) first = j;
        end
        total++;
        if (first !== 4) begin bad++; $display("FAIL start_issue_latency got=%0d want=4", first); end
    endtask

    task automatic test_overflow();
        int k, pushes;
        pushes = 0;
        host_cmd(2'd1, 2'b01, k);
        for (int c = 0; c < 100 && pushes < 19; c++) begin
            drive(1'b0, 1'b1, (n_slot == 1) ? 2'b01 : 2'b00, 1'b0, 2'b00, 2'b00);
            total++;
            if (obs_v !== exp_v) begin
                bad++; $display("FAIL ovf_cycle c%0d got=%h want=%h", c, obs_v, exp_v);
            end
            if (m_slot == 1) begin
                pushes++;
                total++;
                if (pushes <= 18 && (bus.stk_delta !== 2'b01 || bus.issue !== 1'b1)) begin
                    bad++; $display("FAIL ovf_push%0d got=%b want=01", pushes, bus.stk_delta);
                end else if (pushes == 19 && (bus.stk_delta !== (CHK ? 2'b00 : 2'b01) ||
                                              bus.issue !== !CHK)) begin
                    bad++; $display("FAIL ovf_19th got=%b/%b want=%b", bus.stk_delta, bus.issue,
                                    CHK ? 2'b00 : 2'b01);
                end
            end
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        total++;
        if (bus.fault_mask !== (CHK ? 4'b0010 : 4'b0000) || bus.run_mask[2] !== 1'b1 ||
            bus.run_mask[1] !== !CHK) begin
            bad++; $display("FAIL ovf_masks got=%b/%b want_fault=%b", bus.run_mask, bus.fault_mask,
                            CHK ? 4'b0010 : 4'b0000);
        end
    endtask

    task automatic test_underflow_clear();
        int k;
        host_cmd(2'd0, 2'b01, k);
        idle_to(0);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00);
        total++;
        if (obs_v !== exp_v || bus.issue !== !CHK || bus.stk_delta !== (CHK ? 2'b00 : 2'b11)) begin
            bad++; $display("FAIL unf_pop got=%h want=%h", obs_v, exp_v);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        total++;
        if (bus.fault_mask[0] !== CHK) begin
            bad++; $display("FAIL unf_fault got=%b want=%b", bus.fault_mask[0], CHK);
        end
        host_cmd(2'd0, 2'b11, k);
        host_cmd(2'd0, 2'b01, k);
        idle_to(0);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00);
        total++;
        if (obs_v !== exp_v || bus.stk_delta !== 2'b01 || bus.issue !== 1'b1) begin
            bad++; $display("FAIL unf_restart_push got=%h want=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_stop_fault_same_slot();
        int k;
        host_cmd(2'd3, 2'b01, k);
        idle_to(3);
        drive(1'b0, 1'b1, 2'b11, 1'b1, 2'd3, 2'b10);
        total++;
        if (obs_v !== exp_v || bus.ctl_ready !== 1'b1 ||
            bus.stk_delta !== (CHK ? 2'b00 : 2'b11)) begin
            bad++; $display("FAIL same_slot_op got=%h want=%h", obs_v, exp_v);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        total++;
        if (bus.fault_mask[3] !== CHK || bus.run_mask[3] !== 1'b0) begin
            bad++; $display("FAIL same_slot_state got=%b/%b want=%b/0", bus.fault_mask[3],
                            bus.run_mask[3], CHK);
        end
    endtask

    task automatic test_reset_mid_run();
        int k;
        drive(1'b1, 1'b1, 2'b01, 1'b1, 2'd1, 2'b01);
        total++;
        if (bus.ctl_ready !== 1'b0 || bus.issue !== 1'b0) begin
            bad++; $display("FAIL rst_mid_ready got=%b want=0", bus.ctl_ready);
        end
        drive(1'b1, 1'b1, 2'b01, 1'b1, 2'd1, 2'b01);
        total++;
        if (obs_v !== exp_v || bus.slot !== 2'd0 || bus.run_mask !== 4'b0000 ||
            bus.fault_mask !== 4'b0000 || bus.ctl_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_state got=%h want=%h", obs_v, exp_v);
        end
        host_cmd(2'd1, 2'b01, k);
        total++;
        if (k !== 1) begin bad++; $display("FAIL rst_mid_accept got=%0d want=1", k); end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
        total++;
        if (bus.run_mask !== 4'b0010) begin
            bad++; $display("FAIL rst_mid_run got=%b want=0010", bus.run_mask);
        end
    endtask

    task automatic test_random();
        logic pend;
        logic [1:0] th, cm;
        pend = 1'b0; th = 2'b00; cm = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1'b1; th = 2'($urandom); cm = 2'($urandom);
            end
            drive(($urandom_range(0, 96) == 0), 1'($urandom), 2'($urandom), pend, th, cm);
            total++;
            if (obs_v !== exp_v) begin
                bad++; $display("FAIL random cyc%0d got=%h want=%h", i, obs_v, exp_v);
            end
            if (exp_ready) pend = 1'b0;
        end
    endtask

    initial begin
        bus.core_we = 1'b0; bus.core_delta = 2'b00;
        bus.ctl_valid = 1'b0; bus.ctl_thread = 2'b00; bus.ctl_cmd = 2'b00;
        test_reset();
        test_idle();
        test_start_latency();
        test_overflow();
        test_underflow_clear();
        test_stop_fault_same_slot();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/barrel_sched.md
# barrel_sched

Four-thread barrel scheduler for the j1a pipelined core. Sits between the core's execute stage and the round-robin data/return stack rotators. Emits the current thread slot in lock-step with the stack rotation and gates each slot's stack operation by that thread's run state. Optionally tracks per-thread stack depth and faults threads on overflow/underflow. A host-side command port starts, stops and clears threads.

## Interface
- DEPTH, 18: tail entries per stack (matches the stack rotator); legal depth range is 0..DEPTH.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- slot  out  2  thread whose stack is at the rotator head this cycle.
- issue  out  1  slot thread is RUN and its op is not faulting.
- core_we  in  1  core's stack write request for the current slot.
- core_delta  in  2  core's stack delta request ({pop,move}).
- stk_we  out  1  gated write to stack rotator.
- stk_delta  out  2  gated delta to stack rotator.
- ctl_valid  in  1  host command valid.
- ctl_ready  out  1  host command accepted this cycle.
- ctl_thread  in  2  target thread.
- ctl_cmd  in  2  00 nop, 01 start, 10 stop, 11 clear-fault.
- run_mask  out  4  bit t set when thread t is RUN.
- fault_mask  out  4  bit t set when thread t is FAULT.

## Operation
- Slot counter: 2-bit, increments by 1 every cycle, wraps 3->0, never stalls. This is required because the rotator advances unconditionally.
- Per-thread states:
  - IDLE (reset state).
  - RUN.
  - FAULT.
- Gating:
  - stk_we = core_we & issue.
  - stk_delta = issue ? core_delta : 00.
  - A non-issuing slot therefore presents we=0/delta=00, which preserves that thread's stack.
- Depth (STACK_CHECK_EN only):
  - Delta 01 gives +1; delta 11 gives -1; 00 and 10 leave depth unchanged.
  - Overflow: depth==DEPTH with delta 01.
  - Underflow: depth==0 with delta 11.
  - On overflow or underflow in a RUN slot: issue=0, so the op is suppressed. The thread goes to FAULT at the next edge and its depth is held.
- Commands:
  - ctl_ready = ctl_valid & (ctl_thread==slot) & ~reset.
  - A transfer occurs when valid & ready. Host must hold valid/thread/cmd stable until ready; worst-case wait is 3 cycles.
  - start: IDLE->RUN and depth:=0. Ignored in RUN or FAULT.
  - stop: RUN->IDLE. Ignored otherwise.
  - clear-fault: FAULT->IDLE. Ignored otherwise.
  - nop: accepted, no effect.
- Simultaneous events in one slot:
  - Fault detection beats an accepted command. The thread ends in FAULT, and a stop or start issued that cycle is discarded.
  - The gated op for the slot is evaluated against the pre-command state. A stop accepted this slot does not suppress this slot's op.
- Reset:
  - slot=0, all threads IDLE, depths 0, run_mask=0, fault_mask=0, issue=0, stk_we=0, stk_delta=00, ctl_ready=0.
  - Stack contents are not cleared. A subsequent start resets depth only.

## Timing
- slot, issue, stk_we, stk_delta are combinational from registered state plus core inputs (same cycle).
- State/depth updates land at the clock edge ending the slot. They are visible in run_mask/fault_mask on the next cycle and take effect on gating at that thread's next slot, 4 cycles later.
- Command latency: accept edge to first issuing slot is exactly 4 cycles.

## Configuration
- STACK_CHECK_EN defined: depth counters, overflow/underflow detection and FAULT entry are present.
- STACK_CHECK_EN undefined:
  - No depth counters.
  - issue = (state==RUN).
  - fault_mask is constant 0 and FAULT is unreachable; clear-fault is accepted but has no effect.

## Structure
- barrel_pkg holds:
  - NTHREADS=4.
  - Thread-state enum {IDLE,RUN,FAULT}.
  - Command codes CMD_NOP/START/STOP/CLEAR.
  - Delta codes D_PUSH=01, D_POP=11.
- Sub-module barrel_thread_ctx: one per thread, instantiated 4x.
  - Contains the state register and the depth counter.
  - Inputs: sel (slot match), core_delta, cmd strobe.
  - Outputs: state, would-fault.
- barrel_sched holds the slot counter, ctl handshake and output muxing.

## Test plan
- Reset, then idle 8 cycles -> slot cycles 0,1,2,3,0,...; stk_we=0 and stk_delta=00 every cycle; run_mask=0.
- start thread 2 issued while slot=3 -> ctl_ready rises at slot=2 (3 cycles later); run_mask=0100 next cycle; first issue=1 at slot 2, 4 cycles after accept.
- Thread 1 RUN, core pushes (01) in 18 consecutive thread-1 slots, then a 19th -> first 18 pass with stk_delta=01; 19th gives stk_delta=00, issue=0, fault_mask=0010 next cycle; other threads unaffected.
- Thread 0 RUN at depth 0, pop (11) -> suppressed, FAULT; clear-fault -> IDLE; start -> RUN with depth 0, and a push passes.
- Same slot: stop accepted for thread 3 while its op underflows -> fault_mask=1000, run_mask bit 3=0, state FAULT; stop discarded.
- Assert reset mid-run with threads 0 and 2 RUN and a pending ctl_valid -> next cycle slot=0, masks 0, ctl_ready=0 during reset; the command is accepted at the first matching slot after reset deasserts.
